// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler for the shared 4:1 mux / 1:4 demux channel.
// Grants one requester per bounded slot and drives the channel selects {s1,s0}.
module mux_rr_scheduler #(
  parameter int SLOT_LEN = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       base, winner, idx;
  logic             found, any_req, at_last, slot_end;

  assign any_req  = |req;
  assign at_last  = (state == GRANT) && (cnt == CNT_LAST);
  assign slot_end = (state == GRANT) && (at_last || !req[owner]);

  // At a slot end the pointer moves to the owner in the same edge, so the
  // scan must already start after the owner rather than after the stale ptr.
  always_comb begin
    base   = (state == GRANT) ? owner : ptr;
    winner = base;
    found  = 1'b0;
    idx    = base;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (en && any_req) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          gnt_nxt   = 4'b0001 << winner;
          sel_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (slot_end) begin
          ptr_nxt = owner;
          if (en && any_req) begin
            owner_nxt = winner;
            gnt_nxt   = 4'b0001 << winner;
            sel_nxt   = winner;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Selects are held through IDLE so the channel never sees a spurious switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd3;
      sel   <= 2'd0;
      cnt   <= '0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
    end
  end

  assign s1   = sel[1];
  assign s0   = sel[0];
  assign busy = |gnt;
  assign last = at_last;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed self-checking bench for mux_rr_scheduler, including a behavioural
// model of the shared mux/demux channel steered by the scheduler selects.
module tb_mux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt, gnt1;
  logic       s1, s0, busy, last;
  logic       s1_1, s0_1, busy1, last1;
  logic [3:0] w;
  logic       d;
  logic       f;
  logic [3:0] y;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler #(.SLOT_LEN(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .last(last)
  );

  mux_rr_scheduler #(.SLOT_LEN(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt1), .s1(s1_1), .s0(s0_1), .busy(busy1), .last(last1)
  );

  // Shared channel: mux routes w[sel] to f, demux routes d to y[sel].
  assign f = w[{s1, s0}];
  assign y = d ? (4'b0001 << {s1, s0}) : 4'b0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    w     = 4'b0000;
    d     = 1'b0;
    #2;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++;
    if ({s1, s0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_sel: got %b expected %b", {s1, s0}, 2'b00); end
    checks++;
    if ({busy, last} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_last: got %b expected %b", {busy, last}, 2'b00); end
    en  = 1'b1;
    req = 4'b1111;
    step();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_held: got %b expected %b", gnt, 4'b0000); end
    en  = 1'b0;
    req = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic exp_l;
    do_reset();
    en  = 1'b1;
    req = 4'b0100;
    step();
    checks++;
    if ({gnt, s1, s0, busy} !== 7'b0100_10_1) begin errors++; $display("[TB] FAIL single_first: got %b expected %b", {gnt, s1, s0, busy}, 7'b0100_10_1); end
    for (int c = 0; c < 4; c++) begin
      exp_l = (c == 3);
      checks++;
      if ({gnt, last} !== {4'b0100, exp_l}) begin errors++; $display("[TB] FAIL single_cycle%0d: got %b expected %b", c, {gnt, last}, {4'b0100, exp_l}); end
      step();
    end
    checks++;
    if ({gnt, last, busy} !== 6'b0100_0_1) begin errors++; $display("[TB] FAIL single_regrant: got %b expected %b", {gnt, last, busy}, 6'b0100_0_1); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    logic       exp_l;
    int         k;
    do_reset();
    en  = 1'b1;
    req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      k = n % 4;
      exp_g = 4'b0001 << k;
      exp_s = 2'(k);
      for (int c = 0; c < 4; c++) begin
        exp_l = (c == 3);
        checks++;
        if ({gnt, s1, s0, last} !== {exp_g, exp_s, exp_l}) begin
          errors++;
          $display("[TB] FAIL rr_slot%0d_cycle%0d: got %b expected %b", n, c, {gnt, s1, s0, last}, {exp_g, exp_s, exp_l});
        end
        step();
      end
    end
  endtask

  task automatic test_slot_len_one();
    logic [3:0] exp_g;
    do_reset();
    en  = 1'b1;
    req = 4'b1111;
    step();
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      checks++;
      if ({gnt1, last1} !== {exp_g, 1'b1}) begin errors++; $display("[TB] FAIL slot1_cycle%0d: got %b expected %b", i, {gnt1, last1}, {exp_g, 1'b1}); end
      step();
    end
  endtask

  task automatic test_early_release();
    do_reset();
    en  = 1'b1;
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL early_owner1: got %b expected %b", gnt, 4'b0010); end
    step();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL early_second_cycle: got %b expected %b", gnt, 4'b0010); end
    req = 4'b1000;
    step();
    checks++;
    if ({gnt, s1, s0} !== 6'b1000_11) begin errors++; $display("[TB] FAIL early_handover: got %b expected %b", {gnt, s1, s0}, 6'b1000_11); end

    do_reset();
    en  = 1'b1;
    req = 4'b1010;
    step();
    step();
    req = 4'b1001;
    step();
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL early_ptr_after_owner1: got %b expected %b", gnt, 4'b1000); end
    req = 4'b0001;
    step();
    checks++;
    if ({gnt, s1, s0} !== 6'b0001_00) begin errors++; $display("[TB] FAIL early_wrap_to_0: got %b expected %b", {gnt, s1, s0}, 6'b0001_00); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    en  = 1'b1;
    req = 4'b0011;
    step();
    step();
    step();
    step();
    step();
    checks++;
    if ({gnt, s1, s0} !== 6'b0010_01) begin errors++; $display("[TB] FAIL endrop_owner1: got %b expected %b", {gnt, s1, s0}, 6'b0010_01); end
    step();
    en = 1'b0;
    step();
    step();
    checks++;
    if ({gnt, last} !== 5'b0010_1) begin errors++; $display("[TB] FAIL endrop_slot_completes: got %b expected %b", {gnt, last}, 5'b0010_1); end
    step();
    checks++;
    if ({gnt, busy, s1, s0} !== 7'b0000_0_01) begin errors++; $display("[TB] FAIL endrop_idle: got %b expected %b", {gnt, busy, s1, s0}, 7'b0000_0_01); end
    step();
    checks++;
    if ({gnt, s1, s0} !== 6'b0000_01) begin errors++; $display("[TB] FAIL endrop_stay_idle: got %b expected %b", {gnt, s1, s0}, 6'b0000_01); end
    en = 1'b1;
    step();
    checks++;
    if ({gnt, s1, s0} !== 6'b0001_00) begin errors++; $display("[TB] FAIL endrop_resume: got %b expected %b", {gnt, s1, s0}, 6'b0001_00); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en  = 1'b1;
    req = 4'b0100;
    step();
    step();
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL areset_pre: got %b expected %b", gnt, 4'b0100); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, s1, s0, busy, last} !== 8'b0000_00_0_0) begin errors++; $display("[TB] FAIL areset_immediate: got %b expected %b", {gnt, s1, s0, busy, last}, 8'b0000_00_0_0); end
    req = 4'b1001;
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if ({gnt, s1, s0} !== 6'b0001_00) begin errors++; $display("[TB] FAIL areset_first_grant: got %b expected %b", {gnt, s1, s0}, 6'b0001_00); end
  endtask

  task automatic test_datapath();
    logic       exp_f [4];
    logic [3:0] exp_y;
    exp_f = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    w   = 4'b1010;
    d   = 1'b1;
    en  = 1'b1;
    req = 4'b1111;
    step();
    for (int k = 0; k < 4; k++) begin
      exp_y = 4'b0001 << k;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({f, y} !== {exp_f[k], exp_y}) begin errors++; $display("[TB] FAIL datapath_slot%0d_cycle%0d: got %b expected %b", k, c, {f, y}, {exp_f[k], exp_y}); end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slot_len_one();
    test_early_release();
    test_enable_drop();
    test_async_reset();
    test_datapath();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler for the shared 4:1 multiplexer / 1:4 demultiplexer channel (data inputs `w0`..`w3`, `f`, `d`, `y0`..`y3`). Four requesters compete for the channel. The block grants one requester at a time for a bounded time slot and drives the `s1`/`s0` selects of both the mux and the demux, so the mux routes `w[owner]` onto `f` and the demux routes `d` onto `y[owner]`. It is the only driver of the channel selects in the design.

## Interface
- `SLOT_LEN`, default 4: maximum cycles per grant. Legal range 1..15.
- `CNT_W`, default 4: slot counter width. Must satisfy 2^CNT_W > SLOT_LEN.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `en`, input, 1: scheduler enable. While low, no new grants are issued.
- `req`, input, 4: request vector; `req[i]` belongs to the requester on `w{i}`/`y{i}`. Held high while the requester wants the channel.
- `gnt`, output, 4: one-hot grant, registered; all zero when no owner.
- `s1`, `s0`, output, 1 each: channel select, `{s1,s0}` = owner index. Registered.
- `busy`, output, 1: high while a grant is active (`busy` = |`gnt`).
- `last`, output, 1: high on the final cycle of a full-length slot.

## Operation
- State machine with two states: IDLE and GRANT. Internal registers are `owner[1:0]`, `ptr[1:0]` (last served index) and `cnt[CNT_W-1:0]`.
- Reset (asynchronous, `rst_n`=0): state = IDLE; `gnt`=0000; `{s1,s0}`=00; `busy`=0; `last`=0; `cnt`=0; `ptr`=3, so requester 0 has first priority.
- Winner selection (combinational): the first set bit of `req` scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- IDLE:
  - If `en`=1 and |`req`=1: go to GRANT with `owner` = winner, `gnt` = one-hot(winner), `{s1,s0}` = winner, `cnt`=0.
  - Otherwise remain in IDLE.
  - `{s1,s0}` keep their last value in IDLE and do not return to 00.
- GRANT:
  - Each cycle `cnt` increments.
  - The slot ends at the edge where `cnt`=SLOT_LEN-1, or at the edge where `req[owner]`=0 is sampled (early release), whichever comes first.
  - At slot end, `ptr` is set to `owner`. If `en`=1 and any `req` bit is set (including the old owner's), the next winner is granted at the same edge with no idle gap and `cnt`=0. Otherwise go to IDLE with `gnt`=0000.
  - The previous owner is eligible again only after the other requesters, because of the `ptr` update.
- `en` dropped during GRANT: the current slot completes normally (full length or early release), then the block goes to IDLE. No grant is issued while `en`=0.
- `last` = (state==GRANT) && (`cnt`==SLOT_LEN-1). For SLOT_LEN=1, `last` is high on every granted cycle.
- Requests arriving mid-slot never preempt the current owner.
- Invariants: `gnt` is always one-hot or zero; `{s1,s0}` equals the index of the set `gnt` bit whenever `busy`=1.

## Timing
- Request to grant latency is 1 cycle: `req` sampled high at edge N gives `gnt`/`{s1,s0}` valid after edge N.
- A grant with `req[owner]` held lasts exactly SLOT_LEN cycles.
- Early release: `req[owner]` sampled low at edge N means `gnt[owner]` is low after edge N.
- Handover between requesters takes zero idle cycles: `gnt` moves directly from one-hot(a) to one-hot(b) at a single edge.
- Simultaneous full-slot end and owner drop: treated as a single slot end with identical outcome.
- Reset mid-grant: outputs return to reset values immediately (asynchronous). First grant after release of `rst_n` follows the IDLE rules with `ptr`=3.
- Selects change only at clock edges, so the mux/demux path sees at most one select transition per cycle.

## Test plan
- Reset then single request: `req`=0100, `en`=1 → `gnt`=0100 and `{s1,s0}`=10 one cycle later; held for 4 cycles with `last` on the 4th; then re-granted to 0100 with no gap.
- All requesting: `req`=1111 held, SLOT_LEN=4 → grant order 0,1,2,3,0, each exactly 4 cycles, `{s1,s0}` = 00,01,10,11,00, no idle cycles.
- Early release: owner 1 drops `req[1]` in its 2nd cycle while `req`=1010 → `gnt` goes 0010 then 1000 at the next edge; `ptr`=1.
- Enable drop: `en`→0 mid-slot with `req`=0011 → current slot finishes; `gnt`=0000 and `busy`=0 afterwards; `{s1,s0}` hold their last value; `en`→1 resumes with the next index after `ptr`.
- Asynchronous reset: assert `rst_n`=0 mid-grant between clock edges → `gnt`=0000, `{s1,s0}`=00, `busy`=0 without waiting for a clock edge; after release with `req`=1001, requester 0 is granted first.
- Datapath check: with `w`=1010 and `d`=1, a round-robin sweep → `f` follows `w[owner]` (0,1,0,1) and only `y[owner]`=1 each slot.
